// File: rtl/serializer.sv
// Parallel-to-serial converter: MSB-first shift register with a one-entry holding buffer,
// variable word length (1-2 bit words are swallowed) and zero-gap back-to-back output.
module serializer #(
   parameter  int DATA_W = 16,
   localparam int MOD_W  = $clog2(DATA_W)
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [MOD_W-1:0]  data_mod_i,
   input  logic              data_val_i,
   output logic              ready_o,
   output logic              ser_data_o,
   output logic              ser_data_val_o,
   output logic              busy_o
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam logic [MOD_W:0] LEN_FULL = (MOD_W+1)'(DATA_W);
   localparam logic [MOD_W:0] LEN_MIN  = (MOD_W+1)'(2'd3);
   localparam logic [MOD_W:0] CNT_ONE  = (MOD_W+1)'(1'b1);
   localparam logic [MOD_W:0] CNT_ZERO = {(MOD_W+1){1'b0}};

   // A length field of zero encodes a full-width word.
   function automatic logic [MOD_W:0] eff_len(input logic [MOD_W-1:0] mod);
      logic [MOD_W:0] len;
      if (mod == {MOD_W{1'b0}}) begin
         len = LEN_FULL;
      end else begin
         len = {1'b0, mod};
      end
      return len;
   endfunction

   state_t              state_q,    state_d;
   logic [DATA_W-1:0]   shift_q,    shift_d;
   logic [MOD_W:0]      cnt_q,      cnt_d;
   logic [DATA_W-1:0]   buf_data_q, buf_data_d;
   logic [MOD_W:0]      buf_len_q,  buf_len_d;
   logic                buf_full_q, buf_full_d;
   logic                ser_data_q, ser_data_d;
   logic                ser_val_q,  ser_val_d;
   logic                ready_q;
   logic                busy_q;

   logic [MOD_W:0]      in_len;
   logic                take;
   logic [DATA_W-1:0]   ld_word;
   logic [MOD_W:0]      ld_len;

   // Handshake qualification and reload source selection.
   always_comb begin
      in_len  = eff_len(data_mod_i);
      take    = data_val_i && ready_q && (in_len >= LEN_MIN);
      if (buf_full_q) begin
         ld_word = buf_data_q;
         ld_len  = buf_len_q;
      end else begin
         ld_word = data_i;
         ld_len  = in_len;
      end
   end

   // Next-state logic; cnt_q holds the number of bits still to follow the one on the output.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      buf_data_d = buf_data_q;
      buf_len_d  = buf_len_q;
      buf_full_d = buf_full_q;
      ser_data_d = 1'b0;
      ser_val_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (take) begin
               state_d               = ST_SHIFT;
               {ser_data_d, shift_d} = {ld_word, 1'b0};
               ser_val_d             = 1'b1;
               cnt_d                 = ld_len - CNT_ONE;
               buf_full_d            = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (cnt_q != CNT_ZERO) begin
               {ser_data_d, shift_d} = {shift_q, 1'b0};
               ser_val_d             = 1'b1;
               cnt_d                 = cnt_q - CNT_ONE;
               if (take) begin
                  buf_data_d = data_i;
                  buf_len_d  = in_len;
                  buf_full_d = 1'b1;
               end else begin
                  buf_full_d = buf_full_q;
               end
            end else if (buf_full_q || take) begin
               // Last bit on the wire: chain the next word in without a gap.
               {ser_data_d, shift_d} = {ld_word, 1'b0};
               ser_val_d             = 1'b1;
               cnt_d                 = ld_len - CNT_ONE;
               buf_full_d            = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            buf_full_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!srst_i) begin
         state_q    <= ST_IDLE;
         shift_q    <= {DATA_W{1'b0}};
         cnt_q      <= CNT_ZERO;
         buf_data_q <= {DATA_W{1'b0}};
         buf_len_q  <= CNT_ZERO;
         buf_full_q <= 1'b0;
         ser_data_q <= 1'b0;
         ser_val_q  <= 1'b0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         buf_data_q <= buf_data_d;
         buf_len_q  <= buf_len_d;
         buf_full_q <= buf_full_d;
         ser_data_q <= ser_data_d;
         ser_val_q  <= ser_val_d;
         ready_q    <= !buf_full_d;
         busy_q     <= (state_d == ST_SHIFT) || buf_full_d;
      end
   end

   assign ready_o        = ready_q;
   assign ser_data_o     = ser_data_q;
   assign ser_data_val_o = ser_val_q;
   assign busy_o         = busy_q;

endmodule

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 Parameter: DATA_W, 16, parallel word width; SHALL be a power of two, at least 4.
REQ-002 Parameter: MOD_W, $clog2(DATA_W), width of the length field; derived, not overridden.
REQ-003 Port: clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: srst_i  input  1  reset; one clock, reset is synchronous and active-low.
REQ-005 Port: data_i  input  DATA_W  parallel word; bit DATA_W-1 is transmitted first.
REQ-006 Port: data_mod_i  input  MOD_W  number of valid bits taken from the MSB end; 0 means DATA_W.
REQ-007 Port: data_val_i  input  1  word valid; a transfer occurs on an edge where data_val_i and ready_o are both high.
REQ-008 Port: ready_o  input-side flow control  output  1  high when the holding buffer is empty.
REQ-009 Port: ser_data_o  output  1  serial bit; 0 whenever ser_data_val_o is low.
REQ-010 Port: ser_data_val_o  output  1  qualifies ser_data_o, one bit per cycle.
REQ-011 Port: busy_o  output  1  high while a word is shifting or the holding buffer is full.

Function
REQ-012 Storage SHALL be one shift register (active word) plus a one-entry holding buffer; states IDLE and SHIFT.
REQ-013 Effective length N SHALL be DATA_W when data_mod_i=0, else data_mod_i.
REQ-014 A transferred word with N=1 or N=2 SHALL be consumed and discarded: no output bits, no state change beyond the handshake.
REQ-015 IDLE + transfer at edge E: word loads into the shifter, state goes to SHIFT; bit DATA_W-1 is presented with ser_data_val_o=1 in the cycle after E.
REQ-016 In SHIFT, the module SHALL present bits DATA_W-1 down to DATA_W-N on N consecutive cycles, with ser_data_val_o high on each of them.
REQ-017 A transfer while in SHIFT, other than on the last-bit cycle, SHALL write the word into the holding buffer; ready_o falls on the following cycle.
REQ-018 On the last-bit cycle, the shifter SHALL reload from the buffer if it is full, else from a simultaneous transfer, else the state goes to IDLE.
REQ-019 Consecutive words SHALL be emitted with zero gap cycles.
REQ-020 Buffer full + last-bit cycle: the buffer moves to the shifter and ready_o rises the next cycle; data_val_i on that same edge is not transferred.
REQ-021 ready_o SHALL be registered and equal to "holding buffer empty"; data_val_i while ready_o is low SHALL be ignored.
REQ-022 Discarded words (N=1, 2) SHALL neither occupy the buffer nor interrupt the word currently shifting.
REQ-023 The bit counter SHALL be MOD_W+1 bits wide so that N=DATA_W does not wrap.
REQ-024 busy_o SHALL be registered and high iff state is SHIFT or the buffer is full.

Reset
REQ-025 While srst_i=0 at a rising edge, the next cycle SHALL show ser_data_o=0, ser_data_val_o=0, busy_o=0, ready_o=0, state IDLE, buffer empty.
REQ-026 ready_o SHALL be 1 in the first cycle after srst_i returns high.
REQ-027 Reset mid-word SHALL abandon both the active and the buffered word; neither is emitted afterwards.

Verification
REQ-028 Full word: data_i=0xA5C3, data_mod_i=0, single transfer -> 16 valid cycles carrying 1010010111000011 MSB first, busy_o high for exactly 16 cycles.
REQ-029 Short word: data_i=0xE000, data_mod_i=3 -> 3 valid cycles carrying 1,1,1, then ser_data_val_o=0 and busy_o=0.
REQ-030 Discard: data_mod_i=1, then data_mod_i=2 -> ser_data_val_o stays 0, busy_o stays 0, ready_o stays 1.
REQ-031 Back-to-back: word A (0x9000, mod 4) then word B (0xFFFF, mod 0) on the next cycle, word C held valid -> 20 contiguous valid bits 1001 then 16 ones; ready_o low from the cycle after B is accepted; C is transferred only after B enters the shifter.
REQ-032 Stall: toggle data_i while ready_o=0 -> output stream unaffected.
REQ-033 Reset after bit 5 of a 16-bit word with a buffered word present -> outputs 0 the next cycle; no bits of either word appear after reset.
